// File: rtl/occupancy_counter.sv
// Purpose: saturating up/down occupancy counter (0..CAPACITY) for a parking lot.
// Latency: a command sampled at a rising edge is visible on count right after that edge.
// Backpressure: none; one command per cycle is always accepted, and held levels step once per edge.
module occupancy_counter #(
    parameter int WIDTH    = 4,
    parameter int CAPACITY = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       inc_dec,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CAP = CAPACITY[WIDTH-1:0];

    generate
        if (CAPACITY < 1 || CAPACITY > (2 ** WIDTH) - 1) begin : g_bad_capacity
            $error("occupancy_counter: CAPACITY must be in 1..2**WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] count_q = '0;
    logic [WIDTH-1:0] count_nxt;

    // Limits are checked before stepping, so the add/subtract never overflows.
    // Codes 00, 11 and anything unknown fall to the default and hold.
    always_comb begin
        count_nxt = count_q;
        case (inc_dec)
            2'b10: if (count_q < CAP)   count_nxt = count_q + 1'b1;
            2'b01: if (count_q != '0)   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_occupancy_counter.sv
// Bench for occupancy_counter: expected counts are queued as each command is driven
// and compared against the DUT output one clock edge later.
module tb_occupancy_counter;

    localparam int WIDTH    = 4;
    localparam int CAPACITY = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       inc_dec;
    logic [WIDTH-1:0] count;

    int checks   = 0;
    int failures = 0;
    int ref_cnt  = 0;
    int exp_q[$];

    occupancy_counter #(.WIDTH(WIDTH), .CAPACITY(CAPACITY)) dut (
        .clk     (clk),
        .reset   (reset),
        .inc_dec (inc_dec),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: count=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent reference: reset wins, then saturating step on 10/01 only.
    task automatic drive(input logic r, input logic [1:0] cmd, input string tag);
        int exp;
        @(negedge clk);
        reset   = r;
        inc_dec = cmd;
        if (r)                                  ref_cnt = 0;
        else if (cmd == 2'b10 && ref_cnt < CAPACITY) ref_cnt = ref_cnt + 1;
        else if (cmd == 2'b01 && ref_cnt > 0)   ref_cnt = ref_cnt - 1;
        exp_q.push_back(ref_cnt);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, int'(count), exp);
        end
    endtask

    initial begin
        reset   = 1'b0;
        inc_dec = 2'b00;

        // Reset from unknown, with a command present that must be ignored.
        drive(1'b1, 2'b10, "reset_inc");
        drive(1'b1, 2'b01, "reset_dec");

        // Single step up then down.
        drive(1'b0, 2'b10, "step_up");
        drive(1'b0, 2'b01, "step_down");

        // Saturate high: 15 steps to the top, then 5 more held there.
        for (int i = 0; i < 20; i++) drive(1'b0, 2'b10, "sat_high");

        // Back to zero, then saturate low with no wrap.
        drive(1'b1, 2'b00, "reset_mid");
        for (int i = 0; i < 5; i++) drive(1'b0, 2'b01, "sat_low");

        // Hold codes at 7.
        for (int i = 0; i < 7; i++) drive(1'b0, 2'b10, "climb_7");
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, "hold_00");
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b11, "hold_11");
        drive(1'b0, 2'bxx, "hold_x");

        // Reset mid-operation from full while incrementing.
        for (int i = 0; i < 10; i++) drive(1'b0, 2'b10, "refill");
        drive(1'b1, 2'b10, "reset_full");
        drive(1'b0, 2'b01, "dec_after_reset");
        drive(1'b0, 2'b10, "inc_after_reset");

        // Reset asserted between edges only must not clear the count.
        @(negedge clk);
        inc_dec = 2'b00;
        reset   = 1'b1;
        #2;
        reset   = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset_glitch", int'(count), ref_cnt);

        // Pseudo-random mix against the reference.
        for (int i = 0; i < 60; i++) begin
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            drive(($urandom_range(0, 19) == 0), c, "random");
        end

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
